gamepad_poll: RTL
=================

Name: gamepad_poll

Overview:
Next-generation serial gamepad poller for SNES/NES-style shift-register pads. It scans 2^SEL_WIDTH multiplexed groups of DATA_WIDTH pads, each NBITS bits long, and clocks one extra bit per group to detect whether a pad is connected. It repeats scans autonomously at a programmable interval and commits all pad values atomically at the end of each scan. It also produces per-button press events and an update strobe for the CPU-side register bank.

Parameters:
DIV, 150, clk cycles per timed phase (pre-pause, latch, clk-high, clk-low); >=2
SEL_WIDTH, 1, pad-group select width; 0 means a single group
DATA_WIDTH, 2, data lines read in parallel per group
NBITS, 16, button bits shifted per pad (8 = NES, 16 = SNES); 2..31
PERIOD_WIDTH, 16, width of poll_period
Derived: NG = 1<<SEL_WIDTH, NP = NG*DATA_WIDTH, SW = max(SEL_WIDTH,1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
gp_sel  out  SW  group select to pad mux
gp_data  in  DATA_WIDTH  serial data from pads, active-low, pulled up
gp_latch  out  1  pad latch, active-high
gp_clk  out  1  pad clock, idles high
gp_value  out  NP*NBITS  committed buttons, active-high; pad p = group*DATA_WIDTH+line occupies [p*NBITS +: NBITS], bit 0 = first bit shifted
gp_present  out  NP  pad p was connected during the last committed scan
gp_press  out  NP*NBITS  one-cycle newly-pressed mask, valid with stb_update
stb_update  out  1  one-cycle pulse when gp_value/gp_present/gp_press are committed
ctrl_run  in  1  enable continuous polling
poll_period  in  PERIOD_WIDTH  idle gap between scans, in units of DIV cycles

Behaviour:
- Reset: every output is 0 except gp_clk = 1; gp_sel = 0; FSM returns to IDLE; shadow registers and previous values are cleared. Reset mid-scan aborts immediately, and no stb_update is produced.
- Tick: a phase counter clears on every state change; tick asserts on the DIV-th cycle of a timed state. Each timed state therefore lasts exactly DIV cycles.
- FSM states: IDLE, GAP, PRE, LATCH, CLK_HI, CLK_LO, NEXT, COMMIT.
  - IDLE -> PRE when ctrl_run = 1.
  - PRE -> LATCH on tick.
  - LATCH -> CLK_HI on tick. The bit counter clears in LATCH.
  - CLK_HI -> CLK_LO on tick. On that same cycle, sample gp_data into each line's shift register (LSB-first fill) and increment the bit counter.
  - CLK_LO -> CLK_HI on tick while bit_cnt < NBITS+1; otherwise -> NEXT.
  - NEXT (1 cycle): store the NBITS button bits (inverted) and the presence bit into the shadow slot for group gp_sel. If gp_sel == NG-1, go to COMMIT; else increment gp_sel and go to PRE.
  - COMMIT (1 cycle): gp_sel <= 0, then go to GAP.
  - GAP: counts poll_period ticks, then -> PRE if ctrl_run = 1, else -> IDLE. If poll_period == 0, GAP lasts 1 cycle.
- ctrl_run dropping mid-scan does not abort. The current scan finishes all groups and commits, then the FSM enters IDLE from GAP.
- Presence: bit index NBITS (the extra clock) is sampled raw. A connected pad drives 0 after its register empties; an absent pad reads 1 via the pull-up. present = ~raw. For an absent pad, the shadow buttons are forced to 0.
- Pad outputs are registered from the state: gp_latch = (state==LATCH), gp_clk = ~(state==CLK_LO). Both lag the state by 1 cycle.
- Commit is atomic: gp_value, gp_present and gp_press all update in the same cycle.
  - The cycle after COMMIT, stb_update = 1 for exactly 1 cycle.
  - gp_press = new_value & ~old_value, computed against the previously committed gp_value. It is zero on all other cycles.
  - The first scan after reset compares against 0.
- Per-group timing: 2*DIV + (NBITS+1)*2*DIV + 1 cycles.
- SEL_WIDTH = 0: gp_sel is held at 0 and every scan is one group.

Test Plan:
1. DIV=4, NBITS=16, SEL_WIDTH=1, DATA_WIDTH=2; ctrl_run=1, poll_period=0; pad models return 0x1234/0xABCD/0x0001/0x8000 then drive 0. Required response:
   - gp_latch is high exactly 4 cycles per group.
   - 17 gp_clk low pulses per group, each 4 cycles.
   - gp_value = {0x8000,0x0001,0xABCD,0x1234}.
   - gp_present = 4'hF.
   - stb_update is a single pulse.
2. Disconnect pad 2 (gp_data line held 1) -> gp_present = 4'b1011 and pad 2 value = 0 at the next stb_update.
3. Pad 0 goes 0x0000 -> 0x0003 -> 0x0001 over successive scans -> gp_press pad 0 = 0x0003, then 0x0000, each only on the stb_update cycle.
4. poll_period=5 -> 20 cycles of GAP (gp_latch low, gp_clk high) between the COMMIT of one scan and the PRE of the next. poll_period=0 -> back-to-back scans.
5. Drop ctrl_run during group 0 bit 5 -> the scan completes group 1, stb_update fires once, and the FSM returns to IDLE with gp_clk = 1 and gp_sel = 0.
6. Assert rst during group 1 CLK_LO -> the next cycle has gp_clk = 1, gp_latch = 0, all values 0, and no stb_update. Polling resumes cleanly after rst is released with ctrl_run = 1.

Source files
------------

// File: rtl/gamepad_poll_if.sv
// Bundle of pad-side and CPU-side signals for the gamepad poller.
// master: the poller; slave: pads plus the CPU register bank.
interface gamepad_poll_if #(
  parameter int SEL_WIDTH    = 1,
  parameter int DATA_WIDTH   = 2,
  parameter int NBITS        = 16,
  parameter int PERIOD_WIDTH = 16
);
  localparam int NG = 1 << SEL_WIDTH;
  localparam int NP = NG * DATA_WIDTH;
  localparam int SW = (SEL_WIDTH > 0) ? SEL_WIDTH : 1;

  logic [SW-1:0]           gp_sel;
  logic [DATA_WIDTH-1:0]   gp_data;
  logic                    gp_latch;
  logic                    gp_clk;
  logic [NP*NBITS-1:0]     gp_value;
  logic [NP-1:0]           gp_present;
  logic [NP*NBITS-1:0]     gp_press;
  logic                    stb_update;
  logic                    ctrl_run;
  logic [PERIOD_WIDTH-1:0] poll_period;

  modport master (
    output gp_sel, gp_latch, gp_clk, gp_value, gp_present, gp_press, stb_update,
    input  gp_data, ctrl_run, poll_period
  );

  modport slave (
    input  gp_sel, gp_latch, gp_clk, gp_value, gp_present, gp_press, stb_update,
    output gp_data, ctrl_run, poll_period
  );
endinterface

// File: rtl/gamepad_poll.sv
// Serial shift-register gamepad poller: scans all pad groups, detects pad
// presence with one extra clock per group, and commits all values atomically.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | polling disabled, pads idle
// GAP      | idle gap of poll_period ticks between scans
// PRE      | settle time after gp_sel changes, before latching
// LATCH    | gp_latch high, pads capture their buttons
// CLK_HI   | gp_clk high; data sampled on the last cycle
// CLK_LO   | gp_clk low
// NEXT     | store current group into shadow, advance gp_sel
// COMMIT   | publish shadow registers to the CPU side
module gamepad_poll #(
  parameter int DIV          = 150,
  parameter int SEL_WIDTH    = 1,
  parameter int DATA_WIDTH   = 2,
  parameter int NBITS        = 16,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  gamepad_poll_if.master bus
);
  localparam int NG = 1 << SEL_WIDTH;
  localparam int NP = NG * DATA_WIDTH;
  localparam int SW = (SEL_WIDTH > 0) ? SEL_WIDTH : 1;
  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(NBITS + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_PRE, S_LATCH, S_CLK_HI, S_CLK_LO, S_NEXT, S_COMMIT
  } state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           phase;
  logic                    timed;
  logic                    tick;
  logic [BW-1:0]           bit_cnt;
  logic [PERIOD_WIDTH-1:0] gap_left;
  logic                    gap_done;
  logic [SW-1:0]           sel;
  logic                    sel_last;
  logic [NBITS:0]          sr [DATA_WIDTH];
  logic [NP*NBITS-1:0]     shadow_value;
  logic [NP-1:0]           shadow_present;

  logic latch_d, clk_d, shift_en, store_en, commit_en;

  assign timed    = (state inside {S_GAP, S_PRE, S_LATCH, S_CLK_HI, S_CLK_LO});
  assign tick     = timed && (phase == CW'(DIV - 1));
  // A zero period makes GAP a single cycle; otherwise leave on the last tick.
  assign gap_done = (gap_left == '0) || (tick && (gap_left == PERIOD_WIDTH'(1)));
  // With a single group the select never advances.
  assign sel_last = (NG == 1) || (sel == SW'(NG - 1));
  assign bus.gp_sel = sel;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.ctrl_run) state_nxt = S_PRE;
      S_GAP:    if (gap_done) state_nxt = bus.ctrl_run ? S_PRE : S_IDLE;
      S_PRE:    if (tick) state_nxt = S_LATCH;
      S_LATCH:  if (tick) state_nxt = S_CLK_HI;
      S_CLK_HI: if (tick) state_nxt = S_CLK_LO;
      S_CLK_LO: if (tick) state_nxt = (bit_cnt < BW'(NBITS + 1)) ? S_CLK_HI : S_NEXT;
      S_NEXT:   state_nxt = sel_last ? S_COMMIT : S_PRE;
      S_COMMIT: state_nxt = S_GAP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode of the current state.
  always_comb begin
    latch_d   = 1'b0;
    clk_d     = 1'b1;
    shift_en  = 1'b0;
    store_en  = 1'b0;
    commit_en = 1'b0;
    case (state)
      S_LATCH:  latch_d   = 1'b1;
      S_CLK_HI: shift_en  = tick;
      S_CLK_LO: clk_d     = 1'b0;
      S_NEXT:   store_en  = 1'b1;
      S_COMMIT: commit_en = 1'b1;
      default:  ;
    endcase
  end

  // Phase counter restarts on every state change and on each tick.
  always_ff @(posedge clk) begin
    if (rst)                                  phase <= '0;
    else if ((state_nxt != state) || tick)    phase <= '0;
    else if (timed)                           phase <= phase + 1'b1;
  end

  // Gap timer: loaded at commit, counts down one per tick.
  always_ff @(posedge clk) begin
    if (rst)                                              gap_left <= '0;
    else if (commit_en)                                   gap_left <= bus.poll_period;
    else if ((state == S_GAP) && tick && (gap_left != '0)) gap_left <= gap_left - 1'b1;
  end

  // Bit counter and per-line shift registers, filled LSB-first.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      for (int l = 0; l < DATA_WIDTH; l++) sr[l] <= '0;
    end else begin
      if (state == S_LATCH) bit_cnt <= '0;
      else if (shift_en)    bit_cnt <= bit_cnt + 1'b1;
      if (shift_en)
        for (int l = 0; l < DATA_WIDTH; l++) sr[l] <= {bus.gp_data[l], sr[l][NBITS:1]};
    end
  end

  // Group select advances after each group and wraps at commit.
  always_ff @(posedge clk) begin
    if (rst)                        sel <= '0;
    else if (store_en && !sel_last) sel <= sel + 1'b1;
    else if (commit_en)             sel <= '0;
  end

  // Shadow slot for the current group; absent pads report no buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_value   <= '0;
      shadow_present <= '0;
    end else if (store_en) begin
      for (int p = 0; p < NP; p++) begin
        if ((p / DATA_WIDTH) == int'(sel)) begin
          shadow_present[p] <= ~sr[p % DATA_WIDTH][NBITS];
          shadow_value[p*NBITS +: NBITS] <= sr[p % DATA_WIDTH][NBITS] ? '0
                                           : ~sr[p % DATA_WIDTH][NBITS-1:0];
        end
      end
    end
  end

  // Registered pad strobes and the atomic CPU-side commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.gp_latch   <= 1'b0;
      bus.gp_clk     <= 1'b1;
      bus.gp_value   <= '0;
      bus.gp_present <= '0;
      bus.gp_press   <= '0;
      bus.stb_update <= 1'b0;
    end else begin
      bus.gp_latch   <= latch_d;
      bus.gp_clk     <= clk_d;
      bus.stb_update <= commit_en;
      bus.gp_press   <= commit_en ? (shadow_value & ~bus.gp_value) : '0;
      if (commit_en) begin
        bus.gp_value   <= shadow_value;
        bus.gp_present <= shadow_present;
      end
    end
  end
endmodule
